// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_INC    = 4;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  // A request may only go out if its response is guaranteed a buffer slot.
  function automatic logic can_issue(input logic [1:0] occupancy, input logic outstanding);
    int total;
    total = int'(occupancy) + int'(outstanding);
    return total < BUF_DEPTH;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} FIFO; push/pop take effect at the clock edge, flush empties it and wins over both.
// Push and pop in the same cycle are legal at any occupancy, so a full buffer can pop and refill at once.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [Width-1:0]   push_pc,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_instr,
  output logic [Width-1:0]   head_pc,
  output logic [1:0]         count
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [INSTR_W-1:0] instr_q [BUF_DEPTH];
  logic [Width-1:0]   pc_q    [BUF_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count_q;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
      instr_q <= '{default: '0};
      pc_q    <= '{default: '0};
    end else if (flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry response buffer, redirect flush; response reaches decode
// one cycle later (same cycle when FETCH_BYPASS_EN is defined), and fetching stalls while the buffer cannot take another word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [Width-1:0]   imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [Width-1:0]   instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [Width-1:0]   redirect_pc,
  output logic [Width-1:0]   fetch_pc
);

  fetch_state_t       state;
  logic [Width-1:0]   fetch_pc_q;
  logic [Width-1:0]   req_addr_q;
  logic               req_valid_q;
  logic               kill_q;

  logic               transfer;
  logic               outstanding;
  logic               rsp_accept;
  logic               push;
  logic               pop;
  logic               buf_nonempty;
  logic [1:0]         count;
  logic [INSTR_W-1:0] head_instr;
  logic [Width-1:0]   head_pc;

  assign transfer     = req_valid_q && imem_req_ready;
  assign outstanding  = (state == WAIT) || (state == FLUSH);
  assign rsp_accept   = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign buf_nonempty = (count != 2'd0);
  assign pop          = buf_nonempty && instr_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass      = rsp_accept && !buf_nonempty;
  assign push        = rsp_accept && !(bypass && instr_ready);
  assign instr_valid = buf_nonempty || bypass;
  assign instr       = bypass ? imem_rsp_data : head_instr;
  assign instr_pc    = bypass ? req_addr_q : head_pc;
`else
  assign push        = rsp_accept;
  assign instr_valid = buf_nonempty;
  assign instr       = head_instr;
  assign instr_pc    = head_pc;
`endif

  fetch_buffer #(
    .Width(Width)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_instr(imem_rsp_data),
    .push_pc   (req_addr_q),
    .pop       (pop),
    .head_instr(head_instr),
    .head_pc   (head_pc),
    .count     (count)
  );

  // req_addr_q doubles as the pc of the in-flight request until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      req_valid_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
      end
      case (state)
        IDLE: begin
          if (!redirect_valid && can_issue(count, outstanding)) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= fetch_pc_q;
          end
        end
        REQ: begin
          if (transfer) begin
            req_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            if (redirect_valid || kill_q) begin
              state <= FLUSH;
            end else begin
              state      <= WAIT;
              fetch_pc_q <= fetch_pc_q + Width'(PC_INC);
            end
          end else if (redirect_valid) begin
            // The request must stay stable, so remember to discard its response.
            kill_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state <= IDLE;
          end else if (redirect_valid) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (imem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign fetch_pc       = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-reset instance plus a RESET_PC = 0xFFFFFFFC instance on shared inputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        req_valid, instr_valid;
  logic [31:0] req_addr, instr, instr_pc, fetch_pc, rsp_data;
  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_instr, w_instr_pc, w_fetch_pc, w_rsp_data;
  logic [31:0] last_addr = '0;
  logic [31:0] w_last_addr = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Tiny memory: answers with a word derived from the last accepted address.
  always @(posedge clk) begin
    if (req_valid && imem_req_ready) last_addr <= req_addr;
    if (w_req_valid && imem_req_ready) w_last_addr <= w_req_addr;
  end
  assign rsp_data   = word(last_addr);
  assign w_rsp_data = word(w_last_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_pc(fetch_pc)
  );

  fetch_unit #(.Width(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_pc(w_fetch_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_w_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);

    // Streaming: memory and decode always ready
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t1_req_valid", 32'(req_valid), 32'd1);
      check("t1_req_addr", req_addr, 32'(4 * i));
      tick();
      #1;
      check("t1_fetch_pc", fetch_pc, 32'(4 * i + 4));
`ifdef FETCH_BYPASS_EN
      check("t1_byp_valid", 32'(instr_valid), 32'd1);
      check("t1_byp_pc", instr_pc, 32'(4 * i));
      check("t1_byp_instr", instr, word(32'(4 * i)));
`else
      check("t1_no_early_valid", 32'(instr_valid), 32'd0);
`endif
      tick();
`ifdef FETCH_BYPASS_EN
      check("t1_byp_not_stored", 32'(instr_valid), 32'd0);
`else
      check("t1_instr_valid", 32'(instr_valid), 32'd1);
      check("t1_instr_pc", instr_pc, 32'(4 * i));
      check("t1_instr", instr, word(32'(4 * i)));
`endif
      tick();
    end

    // Decode stalled: two words buffer, then fetch stops until released
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b0;
    repeat (6) tick();
    check("t2_head_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_instr", instr, word(32'h0));
    repeat (3) tick();
    check("t2_no_req_full", 32'(req_valid), 32'd0);
    check("t2_fetch_pc", fetch_pc, 32'h8);
    check("t2_head_held", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    check("t2_second_pc", instr_pc, 32'h4);
    check("t2_second_instr", instr, word(32'h4));
    tick();
    check("t2_resume_valid", 32'(req_valid), 32'd1);
    check("t2_resume_addr", req_addr, 32'h8);
    check("t2_drained", 32'(instr_valid), 32'd0);

    // Redirect while waiting on 0x8
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    repeat (4) tick();
    instr_ready = 1'b0;
    repeat (3) tick();
    check("t3_req_addr8", req_addr, 32'h8);
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("t3_buf_before", 32'(instr_valid), 32'd1);
    check("t3_buf_pc", instr_pc, 32'h4);
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    check("t3_fetch_pc", fetch_pc, 32'h100);
    check("t3_no_req_flush", 32'(req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("t3_rsp_dropped", 32'(instr_valid), 32'd0);
    tick();
    check("t3_new_req_valid", 32'(req_valid), 32'd1);
    check("t3_new_req_addr", req_addr, 32'h100);

    // Redirect while the request is not yet accepted
    do_reset();
    instr_ready = 1'b1;
    tick();
    check("t4_req_c1", req_addr, 32'h0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    check("t4_req_c2", req_addr, 32'h0);
    tick();
    redirect_valid = 1'b0;
    check("t4_req_valid_c3", 32'(req_valid), 32'd1);
    check("t4_req_c3", req_addr, 32'h0);
    check("t4_fetch_pc_c3", fetch_pc, 32'h200);
    imem_req_ready = 1'b1;
    tick();
    check("t4_after_xfer", 32'(req_valid), 32'd0);
    check("t4_fetch_pc_kept", fetch_pc, 32'h200);
    imem_rsp_valid = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("t4_rsp_dropped", 32'(instr_valid), 32'd0);
    tick();
    check("t4_new_req_valid", 32'(req_valid), 32'd1);
    check("t4_new_req_addr", req_addr, 32'h200);

    // Redirect in WAIT with a same-cycle response
    do_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (2) tick();
    imem_rsp_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    check("t5_no_bypass_redirect", 32'(instr_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    check("t5_dropped", 32'(instr_valid), 32'd0);
    check("t5_fetch_pc", fetch_pc, 32'h300);
    check("t5_idle", 32'(req_valid), 32'd0);
    tick();
    check("t5_new_req_addr", req_addr, 32'h300);

    // PC wrap and reset in the middle of WAIT
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    tick();
    check("t6_first_addr", w_req_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_fetch_pc", w_fetch_pc, 32'h0);
    repeat (2) tick();
    check("t6_second_valid", 32'(w_req_valid), 32'd1);
    check("t6_second_addr", w_req_addr, 32'h0);
    tick();
    imem_rsp_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_rsp_valid = 1'b1;
    check("t6_rst_req_valid", 32'(w_req_valid), 32'd0);
    check("t6_rst_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0;
    check("t6_stale_ignored", 32'(w_instr_valid), 32'd0);
    check("t6_reissue_valid", 32'(w_req_valid), 32'd1);
    check("t6_reissue_addr", w_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b1;
    #1;
`ifdef FETCH_BYPASS_EN
    check("t6_byp_valid", 32'(w_instr_valid), 32'd1);
    check("t6_byp_pc", w_instr_pc, 32'hFFFF_FFFC);
    check("t6_byp_instr", w_instr, word(32'hFFFF_FFFC));
`else
    check("t6_no_early_valid", 32'(w_instr_valid), 32'd0);
`endif
    tick();
    imem_rsp_valid = 1'b0;
`ifndef FETCH_BYPASS_EN
    check("t6_instr_valid", 32'(w_instr_valid), 32'd1);
    check("t6_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    check("t6_instr", w_instr, word(32'hFFFF_FFFC));
`else
    check("t6_byp_not_stored", 32'(w_instr_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter Width, default 32, PC/address width in bits.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  output  1  instruction-memory request valid.
REQ-006 imem_req_addr  output  Width  request address.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  response data valid; at most one response per accepted request, in order.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  instruction available to decode.
REQ-011 instr  output  32  instruction word.
REQ-012 instr_pc  output  Width  address of instr.
REQ-013 instr_ready  input  1  decode consumes instruction this cycle.
REQ-014 redirect_valid  input  1  branch/jump/trap redirect.
REQ-015 redirect_pc  input  Width  redirect target.
REQ-016 fetch_pc  output  Width  next address to be requested (PC register view).

Function
REQ-017 The block SHALL use an FSM with states IDLE, REQ (request driven, not accepted), WAIT (accepted, awaiting response), FLUSH (awaiting a response to discard).
REQ-018 Request handshake: transfer when imem_req_valid && imem_req_ready; imem_req_valid and imem_req_addr SHALL stay stable until transfer.
REQ-019 At most one request SHALL be outstanding; a new request is issued only when buffer occupancy + outstanding < 2.
REQ-020 IDLE->REQ when space permits; REQ->WAIT on transfer, fetch_pc += 4 (modulo 2^Width, wraps silently); WAIT->IDLE on imem_rsp_valid, response pushed to buffer with its address.
REQ-021 A 2-entry FIFO of {instr, pc} SHALL buffer responses; instr_valid = non-empty; pop on instr_valid && instr_ready; simultaneous push and pop SHALL be legal at any occupancy.
REQ-022 Without bypass, response-to-instr_valid latency SHALL be 1 cycle; request issue to the transfer cycle is 0 cycles when imem_req_ready is high.
REQ-023 Redirect SHALL in the same cycle: empty the buffer (a concurrent pop is ignored), set fetch_pc <= redirect_pc.
REQ-024 Redirect in WAIT without rsp -> FLUSH; in WAIT with same-cycle rsp -> response dropped, IDLE; in REQ without transfer -> request held stable, on transfer -> FLUSH; in REQ with same-cycle transfer -> FLUSH; in IDLE -> IDLE; in FLUSH -> stay FLUSH with new fetch_pc.
REQ-025 FLUSH->IDLE on imem_rsp_valid; that response SHALL never reach the buffer.
REQ-026 imem_rsp_valid in IDLE or REQ is a protocol error and SHALL be ignored.

Reset
REQ-027 On rst high at a clock edge: state IDLE, fetch_pc = RESET_PC, buffer empty, imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-028 Reset SHALL override redirect and abandon any outstanding request; the first request (addr RESET_PC) SHALL be driven the cycle after rst deasserts.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: with buffer empty, no redirect, state WAIT, imem_rsp_valid SHALL drive instr_valid/instr/instr_pc combinationally that cycle; if instr_ready is also high, the word is not stored. Undefined: REQ-022 latency applies, no combinational rsp-to-instr path.

Structure
REQ-030 Package fetch_pkg SHALL hold the FSM state enum, INSTR_W = 32, PC_INC = 4, BUF_DEPTH = 2.
REQ-031 Sub-module fetch_buffer (2-entry FIFO with flush, push, pop, count) SHALL be instantiated once.

Verification
REQ-032 Reset, ready/rsp always 1, instr_ready 1 -> requests 0x0,0x4,0x8..., instr_pc follows, one rsp-to-instr cycle.
REQ-033 instr_ready 0 -> exactly 2 words buffered (0x0,0x4), imem_req_valid stays 0; release -> fetch resumes at 0x8.
REQ-034 Redirect to 0x100 while WAIT on 0x8 -> 0x8 response discarded, next request 0x100, buffer empty same cycle.
REQ-035 imem_req_ready held 0 for 3 cycles with redirect in cycle 2 -> addr stable until transfer, then FLUSH, next request redirect_pc.
REQ-036 RESET_PC = 0xFFFFFFFC -> second request 0x00000000; rst mid-WAIT -> stale response ignored, request 0xFFFFFFFC reissued.
REQ-037 FETCH_BYPASS_EN defined, empty buffer -> instr_valid same cycle as imem_rsp_valid.
